// File: rtl/heading_vector.sv
// Heading-to-Cartesian converter: folds a quarter-wave sincos ROM word by quadrant
// and scales it by an unsigned magnitude to produce signed dx/dy.
module heading_vector #(
  parameter int MAG_W   = 12,
  parameter int ROM_LAT = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [9:0]              in_angle,
  input  logic [MAG_W-1:0]        in_mag,
  output logic [7:0]              rom_addr,
  input  logic [35:0]             rom_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [MAG_W:0]   out_dx,
  output logic signed [MAG_W:0]   out_dy,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the
  // result is held until out_ready is seen.

  typedef enum logic [1:0] {IDLE, WAIT, CALC, DONE} state_t;

  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROM_LAT - 1);
  localparam int PROD_W = 18 + MAG_W;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         quad_r;
  logic [MAG_W-1:0]   mag_r;

  logic [17:0]        s_val, c_val;
  logic [17:0]        cos_mag, sin_mag;
  logic               cos_neg, sin_neg;
  logic [PROD_W-1:0]  prod_x, prod_y;
  logic [MAG_W:0]     p_x, p_y;
  logic [MAG_W:0]     dx_next, dy_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)     state_next = WAIT;
      WAIT: if (cnt == '0)    state_next = CALC;
      CALC:                   state_next = DONE;
      DONE: if (out_ready)    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    dbg_state = state;
  end

  // Quadrant fold: rotate the first-quadrant (cos, sin) pair by quad*90 degrees.
  always_comb begin
    s_val   = rom_q[35:18];
    c_val   = rom_q[17:0];
    cos_mag = c_val;
    sin_mag = s_val;
    cos_neg = 1'b0;
    sin_neg = 1'b0;
    case (quad_r)
      2'd0: begin cos_mag = c_val; cos_neg = 1'b0; sin_mag = s_val; sin_neg = 1'b0; end
      2'd1: begin cos_mag = s_val; cos_neg = 1'b1; sin_mag = c_val; sin_neg = 1'b0; end
      2'd2: begin cos_mag = c_val; cos_neg = 1'b1; sin_mag = s_val; sin_neg = 1'b1; end
      default: begin cos_mag = s_val; cos_neg = 1'b0; sin_mag = c_val; sin_neg = 1'b1; end
    endcase
  end

  // Truncate the Q1.17 product first, then apply the sign so results stay symmetric.
  always_comb begin
    prod_x  = PROD_W'(cos_mag) * PROD_W'(mag_r);
    prod_y  = PROD_W'(sin_mag) * PROD_W'(mag_r);
    p_x     = (MAG_W+1)'(prod_x >> 17);
    p_y     = (MAG_W+1)'(prod_y >> 17);
    dx_next = cos_neg ? -p_x : p_x;
    dy_next = sin_neg ? -p_y : p_y;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      quad_r   <= '0;
      mag_r    <= '0;
      rom_addr <= '0;
      out_dx   <= '0;
      out_dy   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          quad_r   <= in_angle[9:8];
          mag_r    <= in_mag;
          rom_addr <= in_angle[7:0];
          cnt      <= CNT_INIT;
        end
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        CALC: begin
          out_dx <= dx_next;
          out_dy <= dy_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heading_vector.sv
// Bench for heading_vector: sincos ROM model, directed heading cases, backpressure,
// mid-operation reset and randomized requests checked against a rotation model.
module tb_heading_vector;

  localparam int MAG_W   = 12;
  localparam int ROM_LAT = 2;
  localparam int RW      = MAG_W + 1;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [9:0]            in_angle;
  logic [MAG_W-1:0]      in_mag;
  logic [7:0]            rom_addr;
  logic [35:0]           rom_q;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [MAG_W:0] out_dx;
  logic signed [MAG_W:0] out_dy;
  logic [1:0]            dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*RW-1:0] exp_q[$];

  logic [17:0] sin_tab[256];
  logic [17:0] cos_tab[256];
  logic [7:0]  rom_addr_q;

  // clock / reset
  always #5 clock = ~clock;

  heading_vector #(.MAG_W(MAG_W), .ROM_LAT(ROM_LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_angle(in_angle), .in_mag(in_mag),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dx(out_dx), .out_dy(out_dy),
    .dbg_state(dbg_state)
  );

  // ROM with registered address and registered data
  always @(posedge clock) begin
    rom_addr_q <= rom_addr;
    rom_q      <= {sin_tab[rom_addr_q], cos_tab[rom_addr_q]};
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: rotate the first-quadrant unit vector by quad*90 degrees,
  // then scale the magnitude with truncation and reapply the sign.
  function automatic logic [2*RW-1:0] model(input int angle, input int mag);
    int x, y, t, px, py;
    x = int'(cos_tab[angle % 256]);
    y = int'(sin_tab[angle % 256]);
    for (int q = 0; q < angle / 256; q++) begin
      t = x; x = -y; y = t;
    end
    px = ((x < 0) ? -x : x) * mag / 131072;
    py = ((y < 0) ? -y : y) * mag / 131072;
    if (x < 0) px = -px;
    if (y < 0) py = -py;
    return {RW'(px), RW'(py)};
  endfunction

  // driver: one full request / response, with 'hold' cycles of output backpressure
  task automatic run_txn(input string tag, input logic [9:0] angle, input int mag,
                         input int exp_dx, input int exp_dy, input int hold);
    int n;
    logic [2*RW-1:0] e;
    logic signed [MAG_W:0] edx, edy, hdx, hdy;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
    in_valid = 1'b1;
    in_angle = angle;
    in_mag   = MAG_W'(mag);
    @(posedge clock);
    exp_q.push_back({RW'(exp_dx), RW'(exp_dy)});
    #1;
    in_valid = 1'b0;
    in_angle = 10'($urandom);
    in_mag   = MAG_W'($urandom);
    n = 0;
    while (n < 20) begin
      @(posedge clock);
      #1;
      n++;
      if (out_valid) break;
      check({tag, "_busy_ready"}, int'(in_ready), 0);
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check({tag, "_valid_timeout"}, 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    check({tag, "_latency"}, n, ROM_LAT + 1);
    e   = exp_q.pop_front();
    edx = e[2*RW-1 -: RW];
    edy = e[RW-1:0];
    check({tag, "_dx"}, int'(out_dx), int'(edx));
    check({tag, "_dy"}, int'(out_dy), int'(edy));
    check({tag, "_rom_addr"}, int'(rom_addr), int'(angle[7:0]));
    hdx = out_dx;
    hdy = out_dy;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_angle = 10'($urandom);
      @(posedge clock);
      #1;
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_ready"}, int'(in_ready), 0);
      check({tag, "_hold_dx"}, int'(out_dx), int'(hdx));
      check({tag, "_hold_dy"}, int'(out_dy), int'(hdy));
      check({tag, "_hold_addr"}, int'(rom_addr), int'(angle[7:0]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, int'(out_valid), 0);
    check({tag, "_post_ready"}, int'(in_ready), 1);
    check({tag, "_post_dx"}, int'(out_dx), int'(hdx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    logic [2*RW-1:0] m;
    logic signed [MAG_W:0] mdx, mdy;
    logic [9:0] ang;
    int mag;

    for (int i = 0; i < 256; i++) begin
      sin_tab[i] = 18'($rtoi($sin(i * 3.14159265358979 / 512.0) * 131071.0 + 0.5));
      cos_tab[i] = 18'($rtoi($cos(i * 3.14159265358979 / 512.0) * 131071.0 + 0.5));
    end

    // reset with a request already pending
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_angle  = 10'h000;
    in_mag    = MAG_W'(1000);
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dx", int'(out_dx), 0);
    check("rst_dy", int'(out_dy), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    reset_n = 1'b1;

    run_txn("a000", 10'h000, 1000,  999,    0, 0);
    run_txn("a100", 10'h100, 1000,    0,  999, 0);
    run_txn("a200", 10'h200, 1000, -999,    0, 0);
    run_txn("a300", 10'h300, 1000,    0, -999, 0);
    run_txn("a080", 10'h080, 1000,  707,  707, 0);
    run_txn("a280", 10'h280, 1000, -707, -707, 0);
    run_txn("a180", 10'h180, 1000, -707,  707, 0);
    run_txn("a3ff", 10'h3FF, 1000,  999,   -6, 0);
    run_txn("a0ff", 10'h0FF, 4095,   25, 4094, 0);
    run_txn("bp",   10'h080, 1000,  707,  707, 10);
    run_txn("zero", 10'h2A5,    0,    0,    0, 1);

    // reset while waiting on the ROM
    @(negedge clock);
    in_valid = 1'b1;
    in_angle = 10'h080;
    in_mag   = MAG_W'(1000);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_dx", int'(out_dx), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    // randomized requests against the rotation model
    for (int t = 0; t < 40; t++) begin
      ang = 10'($urandom_range(0, 1023));
      case ($urandom_range(0, 3))
        0:       mag = 4095;
        1:       mag = $urandom_range(0, 15);
        default: mag = $urandom_range(0, 4095);
      endcase
      m   = model(int'(ang), mag);
      mdx = m[2*RW-1 -: RW];
      mdy = m[RW-1:0];
      run_txn("rand", ang, mag, int'(mdx), int'(mdy), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
